// File: rtl/cw305_reg_pkg.sv
// Shared constants for the CW305 register bank: register map, ID byte and FSM states.
package cw305_reg_pkg;

  localparam int unsigned REG_ID              = 0;
  localparam int unsigned REG_CRYPT_GO        = 1;
  localparam int unsigned REG_CRYPT_TEXTIN    = 2;
  localparam int unsigned REG_CRYPT_KEY       = 3;
  localparam int unsigned REG_CRYPT_CIPHEROUT = 4;
  localparam int unsigned REG_STATUS          = 5;

  localparam logic [7:0] ID_VALUE = 8'h5A;

  typedef enum logic [1:0] {IDLE, START, RUN} state_e;

endpackage

// File: rtl/cw305_reg_watchdog.sv
// Saturating RUN-cycle counter; flags expiry in the cycle the count reaches Timeout.
module cw305_reg_watchdog #(
  parameter int unsigned Timeout = 4096
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic en_i,
  input  logic clr_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(Timeout + 1);
  localparam logic [CntW-1:0] Limit = CntW'(Timeout);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != Limit)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Expiry is seen in the same cycle the count steps onto the limit.
  assign expired_o = en_i && (cnt_d == Limit);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cw305_reg_bank.sv
// Byte-addressed register bank feeding the polynomial-multiplier core, with start FSM,
// watchdog, result capture and scope trigger.
module cw305_reg_bank
  import cw305_reg_pkg::*;
#(
  parameter int unsigned pBYTECNT_SIZE = 7,
  parameter int unsigned pADDR_WIDTH   = 6,
  parameter int unsigned pDATA_WIDTH   = 128,
  parameter int unsigned pTIMEOUT      = 4096
) (
  input  logic                     crypto_clk,
  input  logic                     reset_i,
  input  logic [pADDR_WIDTH-1:0]   reg_address,
  input  logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
  input  logic [7:0]               write_data,
  input  logic                     reg_write,
  input  logic                     reg_read,
  output logic [7:0]               read_data,
  input  logic                     usb_trigger,
  output logic                     core_start,
  output logic [pDATA_WIDTH-1:0]   core_textin,
  output logic [pDATA_WIDTH-1:0]   core_key,
  input  logic                     core_done,
  input  logic [pDATA_WIDTH-1:0]   core_result,
  output logic                     tio_trigger,
  output logic                     busy
);

  localparam int unsigned NumBytes = pDATA_WIDTH / 8;
  localparam int unsigned IdxW     = (NumBytes > 1) ? $clog2(NumBytes) : 1;

  state_e state_q, state_d;
  logic [NumBytes-1:0][7:0] textin_q, textin_d;
  logic [NumBytes-1:0][7:0] key_q, key_d;
  logic [NumBytes-1:0][7:0] cipher_q, cipher_d;
  logic timeout_q, timeout_d;
  logic overrun_q, overrun_d;
  logic trig_q;
  logic [7:0] read_data_q, read_data_d;

  logic idle, byte_ok, expired, trig_edge, start_req;
  logic sel_go, sel_textin, sel_key, sel_status;
  logic [IdxW-1:0] idx;

  assign idle       = (state_q == IDLE);
  assign byte_ok    = 32'(reg_bytecnt) < NumBytes;
  assign idx        = reg_bytecnt[IdxW-1:0];
  assign sel_go     = 32'(reg_address) == REG_CRYPT_GO;
  assign sel_textin = 32'(reg_address) == REG_CRYPT_TEXTIN;
  assign sel_key    = 32'(reg_address) == REG_CRYPT_KEY;
  assign sel_status = 32'(reg_address) == REG_STATUS;
  assign trig_edge  = usb_trigger & ~trig_q;
  // GO and a trigger edge in the same cycle collapse into one request.
  assign start_req  = idle & ((reg_write & sel_go & write_data[0]) | trig_edge);

  cw305_reg_watchdog #(
    .Timeout(pTIMEOUT)
  ) u_watchdog (
    .clk_i    (crypto_clk),
    .reset_i  (reset_i),
    .en_i     (state_q == RUN),
    .clr_i    (state_q == START),
    .expired_o(expired)
  );

  always_comb begin
    state_d   = state_q;
    textin_d  = textin_q;
    key_d     = key_q;
    cipher_d  = cipher_q;
    timeout_d = timeout_q;
    overrun_d = overrun_q;

    if (reg_write && sel_status) begin
      timeout_d = 1'b0;
      overrun_d = 1'b0;
    end
    if (reg_write && !idle && (sel_go || sel_textin || sel_key)) begin
      overrun_d = 1'b1;
    end
    if (reg_write && idle && byte_ok) begin
      if (sel_textin) textin_d[idx] = write_data;
      if (sel_key)    key_d[idx]    = write_data;
    end

    case (state_q)
      IDLE:  if (start_req) state_d = START;
      START: state_d = RUN;
      RUN: begin
        // Completion takes priority over a same-cycle watchdog expiry.
        if (core_done) begin
          state_d  = IDLE;
          cipher_d = core_result;
        end else if (expired) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    read_data_d = read_data_q;
    if (reg_read) begin
      read_data_d = 8'h00;
      case (32'(reg_address))
        REG_ID:              read_data_d = ID_VALUE;
        REG_CRYPT_GO:        read_data_d = {7'b0, ~idle};
        REG_CRYPT_TEXTIN:    if (byte_ok) read_data_d = textin_q[idx];
        REG_CRYPT_KEY:       if (byte_ok) read_data_d = key_q[idx];
        REG_CRYPT_CIPHEROUT: if (byte_ok) read_data_d = cipher_q[idx];
        REG_STATUS:          read_data_d = {6'b0, timeout_q, overrun_q};
        default:             read_data_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge crypto_clk) begin
    if (reset_i) begin
      state_q     <= IDLE;
      textin_q    <= '0;
      key_q       <= '0;
      cipher_q    <= '0;
      timeout_q   <= 1'b0;
      overrun_q   <= 1'b0;
      trig_q      <= 1'b0;
      read_data_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      textin_q    <= textin_d;
      key_q       <= key_d;
      cipher_q    <= cipher_d;
      timeout_q   <= timeout_d;
      overrun_q   <= overrun_d;
      trig_q      <= usb_trigger;
      read_data_q <= read_data_d;
    end
  end

  assign core_start  = (state_q == START);
  assign busy        = ~idle;
  assign tio_trigger = ~idle;
  assign core_textin = textin_q;
  assign core_key    = key_q;
  assign read_data   = read_data_q;

endmodule

// File: tb/tb_cw305_reg_bank.sv
// Scoreboard bench for cw305_reg_bank: a default instance plus a short-watchdog instance.
module tb_cw305_reg_bank;
  import cw305_reg_pkg::*;

  localparam int unsigned DW = 128;
  localparam logic [DW-1:0] TEXTIN_EXP = 128'h12345678abcdef0187654321deadbeef;
  localparam logic [DW-1:0] RES  = 128'h8a278bf8fa2812bc39e52c76205af377;
  localparam logic [DW-1:0] RES2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [DW-1:0] RES3 = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;

  logic crypto_clk = 1'b0;
  always #5 crypto_clk = ~crypto_clk;

  logic          reset_i;
  logic [5:0]    reg_address;
  logic [6:0]    reg_bytecnt;
  logic [7:0]    write_data;
  logic          reg_write, reg_read, usb_trigger, core_done;
  logic [DW-1:0] core_result;
  logic [7:0]    read_data;
  logic          core_start, tio_trigger, busy;
  logic [DW-1:0] core_textin, core_key;

  logic          wd_reg_write, wd_reg_read, wd_core_done;
  logic [DW-1:0] wd_core_result;
  logic [7:0]    wd_read_data;
  logic          wd_core_start, wd_tio, wd_busy;
  logic [DW-1:0] wd_textin, wd_key;

  cw305_reg_bank dut (
    .crypto_clk (crypto_clk),
    .reset_i    (reset_i),
    .reg_address(reg_address),
    .reg_bytecnt(reg_bytecnt),
    .write_data (write_data),
    .reg_write  (reg_write),
    .reg_read   (reg_read),
    .read_data  (read_data),
    .usb_trigger(usb_trigger),
    .core_start (core_start),
    .core_textin(core_textin),
    .core_key   (core_key),
    .core_done  (core_done),
    .core_result(core_result),
    .tio_trigger(tio_trigger),
    .busy       (busy)
  );

  cw305_reg_bank #(
    .pTIMEOUT(16)
  ) dut_wd (
    .crypto_clk (crypto_clk),
    .reset_i    (reset_i),
    .reg_address(reg_address),
    .reg_bytecnt(reg_bytecnt),
    .write_data (write_data),
    .reg_write  (wd_reg_write),
    .reg_read   (wd_reg_read),
    .read_data  (wd_read_data),
    .usb_trigger(1'b0),
    .core_start (wd_core_start),
    .core_textin(wd_textin),
    .core_key   (wd_key),
    .core_done  (wd_core_done),
    .core_result(wd_core_result),
    .tio_trigger(wd_tio),
    .busy       (wd_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard queues: expected read bytes pushed at issue, popped by the monitor.
  logic [7:0] exp_q[$];
  string      name_q[$];
  logic [7:0] wd_exp_q[$];
  string      wd_name_q[$];

  logic rd_seen = 1'b0, wd_rd_seen = 1'b0;
  int   start_pulses = 0, busy_cyc = 0, tio_cyc = 0, wd_busy_cyc = 0;

  always @(posedge crypto_clk) begin
    rd_seen    <= reg_read;
    wd_rd_seen <= wd_reg_read;
  end

  always @(negedge crypto_clk) begin
    if (core_start)  start_pulses++;
    if (busy)        busy_cyc++;
    if (tio_trigger) tio_cyc++;
    if (wd_busy)     wd_busy_cyc++;
    if (rd_seen) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL read_unexpected: got %0h with no expected entry", read_data);
      end else begin
        check(name_q.pop_front(), DW'(read_data), DW'(exp_q.pop_front()));
      end
    end
    if (wd_rd_seen) begin
      if (wd_exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL wd_read_unexpected: got %0h with no expected entry", wd_read_data);
      end else begin
        check(wd_name_q.pop_front(), DW'(wd_read_data), DW'(wd_exp_q.pop_front()));
      end
    end
  end

  // Core model: core_done arrives 20 cycles after the core_start pulse has ended.
  bit   auto_done = 1'b1;
  event late_done_ev;
  initial begin
    core_done   = 1'b0;
    core_result = '0;
    fork
      forever begin
        @(negedge crypto_clk);
        if (core_start && auto_done) begin
          repeat (21) @(posedge crypto_clk);
          #1 core_done = 1'b1; core_result = RES;
          @(posedge crypto_clk);
          #1 core_done = 1'b0;
        end
      end
      forever begin
        @(late_done_ev);
        @(negedge crypto_clk);
        core_done = 1'b1; core_result = RES3;
        @(negedge crypto_clk);
        core_done = 1'b0;
      end
    join
  end

  task automatic wr(input bit wd, input int unsigned addr, input int unsigned idx,
                    input logic [7:0] d);
    @(negedge crypto_clk);
    reg_address = 6'(addr); reg_bytecnt = 7'(idx); write_data = d;
    if (wd) wd_reg_write = 1'b1; else reg_write = 1'b1;
    @(posedge crypto_clk);
    #1 reg_write = 1'b0; wd_reg_write = 1'b0;
  endtask

  task automatic rd(input bit wd, input int unsigned addr, input int unsigned idx,
                    input logic [7:0] exp, input string name);
    @(negedge crypto_clk);
    reg_address = 6'(addr); reg_bytecnt = 7'(idx);
    if (wd) begin
      wd_exp_q.push_back(exp); wd_name_q.push_back(name); wd_reg_read = 1'b1;
    end else begin
      exp_q.push_back(exp); name_q.push_back(name); reg_read = 1'b1;
    end
    @(posedge crypto_clk);
    #1 reg_read = 1'b0; wd_reg_read = 1'b0;
  endtask

  task automatic wait_idle(input bit wd, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge crypto_clk);
      if (!(wd ? wd_busy : busy)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL %s: busy still high after 200 cycles", name);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  logic [7:0] tin [16];
  int s0, b0, t0;

  initial begin
    tin = '{8'hef, 8'hbe, 8'had, 8'hde, 8'h21, 8'h43, 8'h65, 8'h87,
            8'h01, 8'hef, 8'hcd, 8'hab, 8'h78, 8'h56, 8'h34, 8'h12};
    reset_i = 1'b1; reg_address = '0; reg_bytecnt = '0; write_data = '0;
    reg_write = 1'b0; reg_read = 1'b0; usb_trigger = 1'b0;
    wd_reg_write = 1'b0; wd_reg_read = 1'b0; wd_core_done = 1'b0; wd_core_result = '0;
    repeat (3) @(posedge crypto_clk);
    #1 reset_i = 1'b0;

    check("rst_busy", DW'(busy), '0);
    check("rst_tio", DW'(tio_trigger), '0);
    check("rst_core_start", DW'(core_start), '0);
    check("rst_read_data", DW'(read_data), '0);
    check("rst_textin", core_textin, '0);
    check("rst_key", core_key, '0);
    rd(0, REG_ID, 0, 8'h5A, "id");
    rd(0, REG_STATUS, 0, 8'h00, "rst_status");

    // Operand assembly and readback
    for (int i = 0; i < 16; i++) wr(0, REG_CRYPT_TEXTIN, i, tin[i]);
    wr(0, REG_CRYPT_KEY, 0, 8'h40);
    wr(0, REG_CRYPT_TEXTIN, 16, 8'haa);
    check("textin_word", core_textin, TEXTIN_EXP);
    check("key_word", core_key, 128'h40);
    for (int i = 0; i < 16; i++) rd(0, REG_CRYPT_TEXTIN, i, tin[i], $sformatf("textin_rb%0d", i));
    rd(0, REG_CRYPT_KEY, 0, 8'h40, "key_rb0");
    rd(0, REG_CRYPT_KEY, 1, 8'h00, "key_rb1");
    rd(0, REG_CRYPT_TEXTIN, 16, 8'h00, "textin_oob");

    // Same-cycle write and read return the old byte
    @(negedge crypto_clk);
    reg_address = 6'(REG_CRYPT_TEXTIN); reg_bytecnt = 7'd2; write_data = 8'h99;
    exp_q.push_back(8'had); name_q.push_back("rw_same_cycle");
    reg_write = 1'b1; reg_read = 1'b1;
    @(posedge crypto_clk);
    #1 reg_write = 1'b0; reg_read = 1'b0;
    rd(0, REG_CRYPT_TEXTIN, 2, 8'h99, "rw_after");
    wr(0, REG_CRYPT_TEXTIN, 2, 8'had);

    // Normal GO operation
    s0 = start_pulses; b0 = busy_cyc; t0 = tio_cyc;
    wr(0, REG_CRYPT_GO, 0, 8'h01);
    wait_idle(0, "op1_idle");
    check("op1_starts", DW'(start_pulses - s0), 128'd1);
    check("op1_busy_cycles", DW'(busy_cyc - b0), 128'd22);
    check("op1_tio_cycles", DW'(tio_cyc - t0), 128'd22);
    rd(0, REG_CRYPT_CIPHEROUT, 0, 8'h77, "cipher_b0");
    rd(0, REG_CRYPT_CIPHEROUT, 15, 8'h8a, "cipher_b15");
    rd(0, REG_CRYPT_GO, 0, 8'h00, "go_after");

    // Overrun: writes while busy are dropped and flagged
    s0 = start_pulses;
    wr(0, REG_CRYPT_GO, 0, 8'h01);
    wr(0, REG_CRYPT_TEXTIN, 0, 8'hff);
    wr(0, REG_CRYPT_GO, 0, 8'h01);
    rd(0, REG_CRYPT_GO, 0, 8'h01, "go_busy");
    rd(0, REG_STATUS, 0, 8'h01, "status_overrun_busy");
    wait_idle(0, "op2_idle");
    check("op2_starts", DW'(start_pulses - s0), 128'd1);
    check("op2_textin_stable", core_textin, TEXTIN_EXP);
    rd(0, REG_CRYPT_TEXTIN, 0, 8'hef, "op2_textin_b0");
    rd(0, REG_STATUS, 0, 8'h01, "status_overrun");
    wr(0, REG_STATUS, 0, 8'h00);
    rd(0, REG_STATUS, 0, 8'h00, "status_cleared");

    // Done coincident with watchdog expiry (pTIMEOUT=16): done wins
    b0 = wd_busy_cyc;
    wr(1, REG_CRYPT_GO, 0, 8'h01);
    repeat (16) @(posedge crypto_clk);
    #1 wd_core_done = 1'b1; wd_core_result = RES2;
    @(posedge crypto_clk);
    #1 wd_core_done = 1'b0;
    wait_idle(1, "wd_done_idle");
    check("wd_done_busy_cycles", DW'(wd_busy_cyc - b0), 128'd17);
    rd(1, REG_STATUS, 0, 8'h00, "wd_done_status");
    rd(1, REG_CRYPT_CIPHEROUT, 0, 8'hff, "wd_done_cipher_b0");
    rd(1, REG_CRYPT_CIPHEROUT, 14, 8'h11, "wd_done_cipher_b14");

    // Pure timeout
    b0 = wd_busy_cyc;
    wr(1, REG_CRYPT_GO, 0, 8'h01);
    wait_idle(1, "wd_to_idle");
    check("wd_to_busy_cycles", DW'(wd_busy_cyc - b0), 128'd17);
    check("wd_to_core_start", DW'(wd_core_start), '0);
    check("wd_to_tio", DW'(wd_tio), '0);
    check("wd_operands", wd_textin | wd_key, '0);
    rd(1, REG_STATUS, 0, 8'h02, "wd_to_status");
    rd(1, REG_CRYPT_CIPHEROUT, 0, 8'hff, "wd_to_cipher_kept");

    // Trigger held high with a same-cycle GO -> one start; re-raise starts again
    s0 = start_pulses;
    @(negedge crypto_clk);
    usb_trigger = 1'b1;
    reg_address = 6'(REG_CRYPT_GO); reg_bytecnt = '0; write_data = 8'h01; reg_write = 1'b1;
    @(posedge crypto_clk);
    #1 reg_write = 1'b0;
    repeat (9) @(posedge crypto_clk);
    #1 usb_trigger = 1'b0;
    wait_idle(0, "trig1_idle");
    check("trig_go_one_start", DW'(start_pulses - s0), 128'd1);
    @(negedge crypto_clk);
    usb_trigger = 1'b1;
    wait_idle(0, "trig2_idle");
    usb_trigger = 1'b0;
    check("trig_second_start", DW'(start_pulses - s0), 128'd2);

    // Reset in RUN cycle 5; late done must not load CIPHEROUT
    auto_done = 1'b0;
    s0 = start_pulses;
    wr(0, REG_CRYPT_GO, 0, 8'h01);
    repeat (5) @(posedge crypto_clk);
    #1 reset_i = 1'b1;
    @(posedge crypto_clk);
    #1 reset_i = 1'b0;
    check("rst_mid_busy", DW'(busy), '0);
    check("rst_mid_textin", core_textin, '0);
    check("rst_mid_core_start", DW'(core_start), '0);
    check("rst_mid_tio", DW'(tio_trigger), '0);
    check("rst_mid_starts", DW'(start_pulses - s0), 128'd1);
    ->late_done_ev;
    repeat (3) @(negedge crypto_clk);
    check("late_done_busy", DW'(busy), '0);
    rd(0, REG_CRYPT_GO, 0, 8'h00, "rst_mid_go");
    rd(0, REG_CRYPT_CIPHEROUT, 0, 8'h00, "late_done_cipher_b0");
    rd(0, REG_CRYPT_CIPHEROUT, 15, 8'h00, "late_done_cipher_b15");

    repeat (3) @(negedge crypto_clk);
    check("reads_drained", DW'(exp_q.size() + wd_exp_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cw305_reg_bank.md
# cw305_reg_bank

Byte-addressed register bank between the CW305 USB bus front-end and the polynomial-multiplier core, all on `crypto_clk`. Assembles the 128-bit dense operand (TEXTIN) and 128-bit sparse operand (KEY) from single-byte writes. Launches the core from a GO write or a `usb_trigger` rising edge, and runs a busy/done handshake with a watchdog. Captures the 128-bit result (CIPHEROUT) for byte readback and drives the scope trigger during each operation.

## Interface
- `pBYTECNT_SIZE`, 7: byte-index width within a register.
- `pADDR_WIDTH`, 6: register-select width.
- `pDATA_WIDTH`, 128: operand and result width; byte count `pDATA_WIDTH/8`.
- `pTIMEOUT`, 4096: watchdog limit in cycles, RUN state only.
- `crypto_clk` in 1: sole clock.
- `reset_i` in 1: synchronous, active-high reset.
- `reg_address` in pADDR_WIDTH: register select.
- `reg_bytecnt` in pBYTECNT_SIZE: byte index.
- `write_data` in 8: write byte.
- `reg_write` in 1: one-cycle write strobe.
- `reg_read` in 1: one-cycle read strobe.
- `read_data` out 8: registered read byte.
- `usb_trigger` in 1: external start, already synchronised to `crypto_clk`.
- `core_start` out 1: one-cycle launch pulse.
- `core_textin` out pDATA_WIDTH: dense operand.
- `core_key` out pDATA_WIDTH: sparse operand.
- `core_done` in 1: one-cycle completion pulse.
- `core_result` in pDATA_WIDTH: result; valid while `core_done`=1.
- `tio_trigger` out 1: scope trigger.
- `busy` out 1: operation in progress.

## Operation
- Register map: ID=0x00 (RO, reads 0x5A), GO=0x01, TEXTIN=0x02, KEY=0x03, CIPHEROUT=0x04 (RO), STATUS=0x05.
- Byte `n` of a wide register maps to bits `[8n+7:8n]`. Writes with `n ≥ pDATA_WIDTH/8` are ignored. Reads with `n ≥ pDATA_WIDTH/8` return 0x00.
- GO write, data bit0=1: start request. GO read returns `{7'b0, busy}`.
- STATUS read returns `{6'b0, timeout_flag, overrun_flag}`. Any STATUS write clears both flags.
- States:
  - IDLE → START on start request (GO or `usb_trigger` 0→1 edge).
  - START → RUN unconditionally; `core_start`=1 for this cycle only.
  - RUN → IDLE on `core_done`: CIPHEROUT ← `core_result`.
  - RUN → IDLE when the watchdog reaches `pTIMEOUT`: `timeout_flag` set, CIPHEROUT unchanged.
- `busy` and `tio_trigger` are 1 in START and RUN.
- While busy:
  - TEXTIN, KEY and GO writes are ignored and set sticky `overrun_flag`.
  - `usb_trigger` edges are ignored; they do not set the flag.
  - Operands stay stable throughout the operation.
- Watchdog:
  - Cleared on entering RUN; counts +1 per RUN cycle.
  - Width `$clog2(pTIMEOUT+1)`; it cannot wrap because it stops at `pTIMEOUT`.

## Timing
- Reset values: state=IDLE, `read_data`=0x00, `core_start`=0, `busy`=0, `tio_trigger`=0, TEXTIN/KEY/CIPHEROUT=0, both flags=0, watchdog=0, trigger edge register=0.
- Write takes effect at the clock edge where `reg_write`=1.
- Read latency: `read_data` updates on the edge after `reg_read` and holds until the next read.
- Start request at edge k: `core_start`=1 and `busy`=1 during cycle k+1; RUN from k+2.
- `core_done` at edge m: CIPHEROUT valid and `busy`=0 from cycle m+1.
- Minimum operation length: GO write to `busy` low is 3 cycles.
- Simultaneous events:
  - GO write and trigger edge in the same cycle → one start.
  - `core_done` and watchdog expiry in the same cycle → done wins; no timeout flag.
  - `reg_write` and `reg_read` in the same cycle to the same register → read returns the pre-write value.
- `core_done` outside RUN is ignored.
- `reset_i` mid-operation → everything returns to reset values on the next edge. `core_start` is never left asserted.

## Structure
- Package `cw305_reg_pkg`:
  - register address localparams REG_ID, REG_CRYPT_GO, REG_CRYPT_TEXTIN, REG_CRYPT_KEY, REG_CRYPT_CIPHEROUT, REG_STATUS;
  - ID constant 0x5A;
  - FSM state enum {IDLE, START, RUN}.
- One sub-module, `cw305_reg_watchdog`: counter plus expiry compare, with enable/clear inputs and an `expired` output.
- Address decode, byte lanes, FSM and read mux stay in the top module.

## Test plan
- Write TEXTIN bytes 0..15 = 0xef,0xbe,0xad,0xde,0x21,0x43,0x65,0x87,0x01,0xef,0xcd,0xab,0x78,0x56,0x34,0x12, then KEY byte0=0x40 → `core_textin`=128'h12345678abcdef0187654321deadbeef and `core_key`=128'h40. Readback of each byte matches, 1-cycle latency.
- GO write of 0x01; model drives `core_done` 20 cycles after `core_start` with result 128'h8a278bf8fa2812bc39e52c76205af377 → exactly one `core_start` pulse; `busy` and `tio_trigger` are 1 for 22 cycles. CIPHEROUT byte0 reads 0x77, byte15 reads 0x8a; GO reads 0x00 afterwards.
- While busy, write TEXTIN byte0=0xFF and GO=0x01 → TEXTIN is unchanged, no second `core_start`, STATUS=0x01. A STATUS write then clears it to 0x00.
- `core_done` never asserted, `pTIMEOUT`=16 → `busy` drops after the RUN cycle in which the watchdog reaches 16; STATUS=0x02; CIPHEROUT is unchanged.
- `usb_trigger` held high for 10 cycles together with a same-cycle GO write → exactly one start. Raising `usb_trigger` again after `core_done` starts a second operation.
- Assert `reset_i` in RUN cycle 5 → next cycle `busy`=0, TEXTIN=0 and state IDLE; a late `core_done` pulse does not update CIPHEROUT.
